axi_icache_refill: RTL and testbench
====================================

AXI_ICACHE_REFILL -- requirements
Module: axi_icache_refill

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 64, R data width; power of 2, >=32.
REQ-003 SHALL have parameter AXI_ID_WIDTH, default 4, ID width.
REQ-004 SHALL have parameter AXI_ID, default 0, ARID driven and RID expected.
REQ-005 SHALL have parameter LINE_BYTES, default 32, cache line size; BEATS = LINE_BYTES/(AXI_DATA_WIDTH/8), power of 2, 1..16.
REQ-006 SHALL have parameter WRAP_EN, default 1; 1 = critical-word-first WRAP burst, 0 = line-aligned INCR burst.
REQ-007 One clock, clk_i; reset is synchronous, active-high, rst_i.
REQ-008 Ports (name dir width meaning):
- clk_i in 1 clock
- rst_i in 1 sync active-high reset
- ic_req_valid_i in 1 miss request
- ic_req_ready_o out 1 request accepted when both high
- ic_req_addr_i in AXI_ADDR_WIDTH miss byte address
- ic_rsp_valid_o out 1 line ready
- ic_rsp_ready_i in 1 cache takes line
- ic_rsp_line_o out LINE_BYTES*8 assembled line, word i at bits [i*DATA_W +: DATA_W]
- ic_rsp_err_o out 1 refill error
- axi_arid_o out AXI_ID_WIDTH; axi_araddr_o out AXI_ADDR_WIDTH; axi_arlen_o out 8; axi_arsize_o out 3; axi_arburst_o out 2; axi_arvalid_o out 1; axi_arready_i in 1
- axi_rid_i in AXI_ID_WIDTH; axi_rdata_i in AXI_DATA_WIDTH; axi_rresp_i in 2; axi_rlast_i in 1; axi_rvalid_i in 1; axi_rready_o out 1

Function
REQ-009 FSM states IDLE, AR_SEND, R_COLLECT, RESP; ic_req_ready_o=1 only in IDLE.
REQ-010 IDLE: valid&&ready captures address, clears error and beat counter -> AR_SEND next cycle.
REQ-011 AR_SEND: arvalid=1; arid=AXI_ID, arlen=BEATS-1, arsize=log2(DATA_W/8), all AR fields stable until arready; arvalid&&arready -> R_COLLECT.
REQ-012 WRAP_EN=1: araddr = addr aligned to beat, arburst=2'b10, start index = addr beat offset within line; if BEATS=1, arburst=2'b01.
REQ-013 WRAP_EN=0: araddr = addr aligned to line, arburst=2'b01, start index 0.
REQ-014 R_COLLECT: rready=1; each rvalid beat writes rdata to line word (start+count) mod BEATS; count increments mod BEATS.
REQ-015 Error sticky-set on any beat with rresp[1]=1, rid!=AXI_ID, rlast on beat count<BEATS-1, or missing rlast on beat BEATS-1.
REQ-016 Missing rlast: keep rready=1, discard further beats (no line write) until rlast, then RESP.
REQ-017 Beat with rlast -> RESP next cycle, regardless of count.
REQ-018 RESP: ic_rsp_valid_o=1, line/err stable until ic_rsp_ready_i; handshake -> IDLE; new request accepted no earlier than following cycle.
REQ-019 Latency: request accept cycle N -> arvalid N+1; rlast beat cycle M -> rsp_valid M+1.
REQ-020 rready=0 and arvalid=0 outside R_COLLECT / AR_SEND respectively; R beats outside R_COLLECT ignored.
REQ-021 Beat counter wraps mod BEATS; no arithmetic overflow beyond log2(BEATS) bits.

Reset
REQ-022 rst_i high at clk_i edge: state IDLE, arvalid=0, rready=0, rsp_valid=0, err=0, line buffer=0, counter=0, ic_req_ready_o=1 after release.
REQ-023 Reset mid-burst aborts silently; in-flight AR/R not drained (interconnect reset concurrently).

Verification
REQ-024 WRAP_EN=1, 64b, 32B: req 0x1018 -> araddr 0x1018, arlen 3, arsize 3, arburst 2; beats D0..D3 -> words[3]=D0,[0]=D1,[1]=D2,[2]=D3, err 0.
REQ-025 WRAP_EN=0: req 0x1018 -> araddr 0x1000, arburst 1; beats D0..D3 -> words[0..3]=D0..D3.
REQ-026 arready low 5 cycles -> arvalid and all AR fields constant for 5 cycles, handshake on 6th.
REQ-027 rresp=2'b10 on beat 2 -> all 4 beats collected, ic_rsp_err_o=1.
REQ-028 rlast on beat 1 -> RESP one cycle later, err=1; rsp_ready low 3 cycles -> rsp_valid/line held, ic_req_ready_o=0.
REQ-029 rst_i asserted during beat 2 -> next cycle IDLE, rready=0, rsp_valid=0; fresh request completes normally.

Source files
------------

// File: rtl/axi_icache_refill.sv
// axi_icache_refill: fetches one instruction-cache line over an AXI read burst.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   ic_req_*                miss request (valid/ready, byte address)
//   ic_rsp_*                assembled line plus sticky error (valid/ready)
//   axi_ar*                 single read-address request per miss
//   axi_r*                  read data beats, always accepted while collecting
module axi_icache_refill #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_ID         = 0,
    parameter int LINE_BYTES     = 32,
    parameter int WRAP_EN        = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      ic_req_valid_i,
    output logic                      ic_req_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0] ic_req_addr_i,
    output logic                      ic_rsp_valid_o,
    input  logic                      ic_rsp_ready_i,
    output logic [LINE_BYTES*8-1:0]   ic_rsp_line_o,
    output logic                      ic_rsp_err_o,
    output logic [AXI_ID_WIDTH-1:0]   axi_arid_o,
    output logic [AXI_ADDR_WIDTH-1:0] axi_araddr_o,
    output logic [7:0]                axi_arlen_o,
    output logic [2:0]                axi_arsize_o,
    output logic [1:0]                axi_arburst_o,
    output logic                      axi_arvalid_o,
    input  logic                      axi_arready_i,
    input  logic [AXI_ID_WIDTH-1:0]   axi_rid_i,
    input  logic [AXI_DATA_WIDTH-1:0] axi_rdata_i,
    input  logic [1:0]                axi_rresp_i,
    input  logic                      axi_rlast_i,
    input  logic                      axi_rvalid_i,
    output logic                      axi_rready_o
);
    localparam int DW    = AXI_DATA_WIDTH;
    localparam int BYTES = DW / 8;
    localparam int BEATS = LINE_BYTES / BYTES;
    localparam int OFFW  = $clog2(BYTES);
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [AXI_ADDR_WIDTH-1:0] MASK =
        AXI_ADDR_WIDTH'((WRAP_EN != 0) ? BYTES - 1 : LINE_BYTES - 1);
    typedef enum logic [1:0] {IDLE, AR_SEND, R_COLLECT, RESP} state_t;
    state_t                    r_state;
    logic [AXI_ADDR_WIDTH-1:0] r_araddr;
    logic [CW-1:0]             r_start;
    logic [CW-1:0]             r_cnt;
    logic                      r_err;
    logic                      r_drop;
    logic                      r_req_ready;
    logic                      r_arvalid;
    logic                      r_rready;
    logic                      r_rsp_valid;
    logic [LINE_BYTES*8-1:0]   r_line;
    logic [CW-1:0]             w_start;
    logic [CW-1:0]             w_idx;
    logic                      w_last_beat;
    logic                      w_bad;
    // Critical word first: the burst starts at the missed beat and wraps within the line.
    assign w_start     = (WRAP_EN != 0 && BEATS > 1) ? CW'(ic_req_addr_i >> OFFW) : '0;
    // CW-bit addition wraps naturally because BEATS is a power of two.
    assign w_idx       = r_start + r_cnt;
    assign w_last_beat = r_cnt == CW'(BEATS - 1);
    // rresp >= 2 is SLVERR/DECERR; rlast must appear exactly on the final beat.
    assign w_bad       = (axi_rresp_i >= 2'b10) || (axi_rid_i != AXI_ID_WIDTH'(AXI_ID)) ||
                         (axi_rlast_i != w_last_beat);
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_araddr    <= '0;
            r_start     <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_drop      <= 1'b0;
            r_req_ready <= 1'b1;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_line      <= '0;
        end else begin
            case (r_state)
                IDLE: if (ic_req_valid_i) begin
                    r_araddr    <= ic_req_addr_i & ~MASK;
                    r_start     <= w_start;
                    r_cnt       <= '0;
                    r_err       <= 1'b0;
                    r_drop      <= 1'b0;
                    r_req_ready <= 1'b0;
                    r_arvalid   <= 1'b1;
                    r_state     <= AR_SEND;
                end
                AR_SEND: if (axi_arready_i) begin
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b1;
                    r_state   <= R_COLLECT;
                end
                R_COLLECT: if (axi_rvalid_i) begin
                    if (!r_drop)
                        r_line[w_idx*DW +: DW] <= axi_rdata_i;
                    if (w_bad)
                        r_err <= 1'b1;
                    r_cnt <= r_cnt + CW'(BEATS > 1);
                    if (axi_rlast_i) begin
                        r_rready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else if (w_last_beat) begin
                        // Line is full but the burst overran: swallow beats until rlast.
                        r_drop <= 1'b1;
                    end
                end
                RESP: if (ic_rsp_ready_i) begin
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign ic_req_ready_o = r_req_ready;
    assign ic_rsp_valid_o = r_rsp_valid;
    assign ic_rsp_line_o  = r_line;
    assign ic_rsp_err_o   = r_err;
    assign axi_arid_o     = AXI_ID_WIDTH'(AXI_ID);
    assign axi_araddr_o   = r_araddr;
    assign axi_arlen_o    = 8'(BEATS - 1);
    assign axi_arsize_o   = 3'(OFFW);
    assign axi_arburst_o  = (WRAP_EN != 0 && BEATS > 1) ? 2'b10 : 2'b01;
    assign axi_arvalid_o  = r_arvalid;
    assign axi_rready_o   = r_rready;
endmodule

// File: tb/tb_axi_icache_refill.sv
// tb_axi_icache_refill: scoreboard bench driving a WRAP and an INCR refill unit in lockstep.
module tb_axi_icache_refill;
    typedef struct {
        logic [31:0] addr;
        logic [1:0]  burst;
    } ar_t;
    typedef struct {
        logic [255:0] line;
        logic         err;
    } rsp_t;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic [31:0]  req_addr = '0;
    logic         rsp_ready = 1'b0;
    logic         arready = 1'b0;
    logic [3:0]   rid = '0;
    logic [63:0]  rdata = '0;
    logic [1:0]   rresp = '0;
    logic         rlast = 1'b0;
    logic         rvalid = 1'b0;
    logic         req_ready [2];
    logic         rsp_valid [2];
    logic [255:0] line [2];
    logic         err [2];
    logic [3:0]   arid [2];
    logic [31:0]  araddr [2];
    logic [7:0]   arlen [2];
    logic [2:0]   arsize [2];
    logic [1:0]   arburst [2];
    logic         arvalid [2];
    logic         rready [2];
    int           errors = 0;
    int           checks = 0;
    ar_t          ar_q0 [$];
    ar_t          ar_q1 [$];
    rsp_t         rsp_q0 [$];
    rsp_t         rsp_q1 [$];
    logic [255:0] mline [2];
    always #5 clk = ~clk;
    axi_icache_refill #(.WRAP_EN(1)) u_wrap (
        .clk_i(clk), .rst_i(rst),
        .ic_req_valid_i(req_valid), .ic_req_ready_o(req_ready[0]), .ic_req_addr_i(req_addr),
        .ic_rsp_valid_o(rsp_valid[0]), .ic_rsp_ready_i(rsp_ready), .ic_rsp_line_o(line[0]),
        .ic_rsp_err_o(err[0]),
        .axi_arid_o(arid[0]), .axi_araddr_o(araddr[0]), .axi_arlen_o(arlen[0]),
        .axi_arsize_o(arsize[0]), .axi_arburst_o(arburst[0]), .axi_arvalid_o(arvalid[0]),
        .axi_arready_i(arready),
        .axi_rid_i(rid), .axi_rdata_i(rdata), .axi_rresp_i(rresp), .axi_rlast_i(rlast),
        .axi_rvalid_i(rvalid), .axi_rready_o(rready[0])
    );
    axi_icache_refill #(.WRAP_EN(0)) u_incr (
        .clk_i(clk), .rst_i(rst),
        .ic_req_valid_i(req_valid), .ic_req_ready_o(req_ready[1]), .ic_req_addr_i(req_addr),
        .ic_rsp_valid_o(rsp_valid[1]), .ic_rsp_ready_i(rsp_ready), .ic_rsp_line_o(line[1]),
        .ic_rsp_err_o(err[1]),
        .axi_arid_o(arid[1]), .axi_araddr_o(araddr[1]), .axi_arlen_o(arlen[1]),
        .axi_arsize_o(arsize[1]), .axi_arburst_o(arburst[1]), .axi_arvalid_o(arvalid[1]),
        .axi_arready_i(arready),
        .axi_rid_i(rid), .axi_rdata_i(rdata), .axi_rresp_i(rresp), .axi_rlast_i(rlast),
        .axi_rvalid_i(rvalid), .axi_rready_o(rready[1])
    );
    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    function automatic logic [63:0] beat(input int t, input int b);
        return {32'(t), 32'hBEA7_0000 | 32'(b)};
    endfunction
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic check_both(input string name, input logic v0, input logic v1, input logic exp);
        chk({name, "_wrap"}, 256'(v0), 256'(exp));
        chk({name, "_incr"}, 256'(v1), 256'(exp));
    endtask
    task automatic ar_expect(input logic [31:0] a);
        ar_q0.push_back('{a & ~32'h7, 2'b10});
        ar_q1.push_back('{a & ~32'h1F, 2'b01});
    endtask
    task automatic issue_req(input logic [31:0] a);
        check_both("req_ready_idle", req_ready[0], req_ready[1], 1'b1);
        req_valid = 1'b1;
        req_addr  = a;
        step();
        req_valid = 1'b0;
        check_both("arvalid_n_plus_1", arvalid[0], arvalid[1], 1'b1);
    endtask
    task automatic ar_phase(input logic [31:0] a, input int dly);
        for (int i = 0; i < dly; i++) begin
            check_both("arvalid_hold", arvalid[0], arvalid[1], 1'b1);
            chk("araddr_hold_wrap", 256'(araddr[0]), 256'(a & ~32'h7));
            chk("araddr_hold_incr", 256'(araddr[1]), 256'(a & ~32'h1F));
            chk("arlen_hold", 256'(arlen[0]), 256'd3);
            step();
        end
        arready = 1'b1;
        step();
        arready = 1'b0;
        check_both("rready_collect", rready[0], rready[1], 1'b1);
        check_both("arvalid_done", arvalid[0], arvalid[1], 1'b0);
    endtask
    task automatic run(input int t, input logic [31:0] a, input int nb, input int last_at,
                       input int bad_resp_at, input int bad_id_at, input int ar_dly, input int rsp_dly);
        int   s;
        logic e;
        s = int'(a[4:3]);
        ar_expect(a);
        for (int b = 0; b < nb && b < 4; b++) begin
            mline[0][((s + b) % 4) * 64 +: 64] = beat(t, b);
            mline[1][b * 64 +: 64]             = beat(t, b);
        end
        e = (bad_resp_at < nb) || (bad_id_at < nb) || (last_at != 3);
        rsp_q0.push_back('{mline[0], e});
        rsp_q1.push_back('{mline[1], e});
        issue_req(a);
        ar_phase(a, ar_dly);
        for (int b = 0; b < nb; b++) begin
            rvalid = 1'b1;
            rdata  = beat(t, b);
            rresp  = (b == bad_resp_at) ? 2'b10 : 2'b00;
            rid    = (b == bad_id_at) ? 4'h5 : 4'h0;
            rlast  = (b == last_at);
            step();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        rid    = 4'h0;
        check_both("rsp_valid_m_plus_1", rsp_valid[0], rsp_valid[1], 1'b1);
        check_both("rready_after_last", rready[0], rready[1], 1'b0);
        for (int i = 0; i < rsp_dly; i++) begin
            check_both("rsp_valid_hold", rsp_valid[0], rsp_valid[1], 1'b1);
            check_both("req_ready_busy", req_ready[0], req_ready[1], 1'b0);
            chk("line_hold_wrap", line[0], mline[0]);
            chk("err_hold_wrap", 256'(err[0]), 256'(e));
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check_both("rsp_valid_drop", rsp_valid[0], rsp_valid[1], 1'b0);
        check_both("req_ready_back", req_ready[0], req_ready[1], 1'b1);
    endtask
    task automatic reset_mid_burst(input int t, input logic [31:0] a);
        ar_expect(a);
        issue_req(a);
        ar_phase(a, 1);
        for (int b = 0; b < 3; b++) begin
            rvalid = 1'b1;
            rdata  = beat(t, b);
            rst    = (b == 2);
            step();
        end
        rst    = 1'b0;
        rvalid = 1'b0;
        mline[0] = '0;
        mline[1] = '0;
        check_both("rst_req_ready", req_ready[0], req_ready[1], 1'b1);
        check_both("rst_rready", rready[0], rready[1], 1'b0);
        check_both("rst_rsp_valid", rsp_valid[0], rsp_valid[1], 1'b0);
        check_both("rst_arvalid", arvalid[0], arvalid[1], 1'b0);
        chk("rst_line_wrap", line[0], '0);
        chk("rst_line_incr", line[1], '0);
        rvalid = 1'b1;
        rlast  = 1'b1;
        rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        rvalid = 1'b0;
        rlast  = 1'b0;
        chk("idle_beat_ignored_wrap", line[0], '0);
        check_both("idle_beat_no_rsp", rsp_valid[0], rsp_valid[1], 1'b0);
    endtask
    task automatic monitor();
        ar_t  ea;
        rsp_t er;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst && arvalid[d] && arready) begin
                    if ((d == 0 ? ar_q0.size() : ar_q1.size()) == 0) begin
                        chk("ar_unexpected", 256'd1, 256'd0);
                    end else begin
                        ea = (d == 0) ? ar_q0.pop_front() : ar_q1.pop_front();
                        chk(d == 0 ? "araddr_wrap" : "araddr_incr", 256'(araddr[d]), 256'(ea.addr));
                        chk(d == 0 ? "arburst_wrap" : "arburst_incr", 256'(arburst[d]), 256'(ea.burst));
                        chk("arlen", 256'(arlen[d]), 256'd3);
                        chk("arsize", 256'(arsize[d]), 256'd3);
                        chk("arid", 256'(arid[d]), 256'd0);
                    end
                end
                if (!rst && rsp_valid[d] && rsp_ready) begin
                    if ((d == 0 ? rsp_q0.size() : rsp_q1.size()) == 0) begin
                        chk("rsp_unexpected", 256'd1, 256'd0);
                    end else begin
                        er = (d == 0) ? rsp_q0.pop_front() : rsp_q1.pop_front();
                        chk(d == 0 ? "line_wrap" : "line_incr", line[d], er.line);
                        chk(d == 0 ? "err_wrap" : "err_incr", 256'(err[d]), 256'(er.err));
                    end
                end
            end
        end
    endtask
    initial begin
        mline[0] = '0;
        mline[1] = '0;
        fork
            monitor();
        join_none
        step();
        step();
        rst = 1'b0;
        step();
        check_both("reset_req_ready", req_ready[0], req_ready[1], 1'b1);
        check_both("reset_arvalid", arvalid[0], arvalid[1], 1'b0);
        check_both("reset_rready", rready[0], rready[1], 1'b0);
        check_both("reset_rsp_valid", rsp_valid[0], rsp_valid[1], 1'b0);
        check_both("reset_err", err[0], err[1], 1'b0);
        chk("reset_line", line[0] | line[1], '0);
        run(1, 32'h0000_1018, 4, 3, 9, 9, 0, 0);
        run(2, 32'h0000_2004, 4, 3, 9, 9, 5, 1);
        run(3, 32'h0000_3008, 4, 3, 2, 9, 1, 0);
        run(4, 32'h0000_4010, 2, 1, 9, 9, 0, 3);
        run(5, 32'h0000_7008, 6, 5, 9, 9, 0, 0);
        run(6, 32'h0000_8000, 4, 3, 9, 1, 2, 0);
        reset_mid_burst(7, 32'h0000_5018);
        run(8, 32'h0000_6018, 4, 3, 9, 9, 0, 1);
        step();
        step();
        chk("ar_queue_drained", 256'(ar_q0.size() + ar_q1.size()), '0);
        chk("rsp_queue_drained", 256'(rsp_q0.size() + rsp_q1.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
